controlador_suma_multipalabra: RTL and testbench



---
 rtl/controlador_suma_multipalabra.sv | 141 ++++++++++++++
 tb/tb_controlador_suma_multipalabra.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_suma_multipalabra.sv
// Wide add/subtract sequencer: one shared N-bit ripple adder processes a
// K-word operand pair one word per clock, LSW first, carry kept in a flop.

module sumador_N #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

module controlador_suma_multipalabra #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N*K-1:0] A_in,
  input  logic [N*K-1:0] B_in,
  output logic         busy,
  output logic         done,
  output logic [N*K-1:0] result,
  output logic         carry_out,
  output logic         overflow
);
  localparam int W  = N * K;
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic            op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            co_q, co_d, ov_q, ov_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [N-1:0]    word_a, word_b, word_s;
  logic            word_co;

  assign word_a = a_q[idx_q*N +: N];
  assign word_b = b_q[idx_q*N +: N];

  sumador_N #(.N(N)) u_sum (
    .a    (word_a),
    .b    (word_b),
    .cin  (cy_q),
    .s    (word_s),
    .cout (word_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: if (start) begin
        a_d     = A_in;
        b_d     = B_in;
        op_d    = op;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // subtract becomes A + ~B + 1: invert B once, seed carry with op
        idx_d   = '0;
        cy_d    = op_q;
        if (op_q) b_d = ~b_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        res_d[idx_q*N +: N] = word_s;
        cy_d  = word_co;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(K-1)) begin
          idx_d   = '0;
          co_d    = word_co;
          ov_d    = (a_q[W-1] == b_q[W-1]) && (word_s[N-1] != a_q[W-1]);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_controlador_suma_multipalabra.sv
// Directed bench: cycle-level behavioural model plus literal expectations
// for the N=4, K=4 wide add/subtract sequencer.

module tb_controlador_suma_multipalabra;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  controlador_suma_multipalabra #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A_in      (A_in),
    .B_in      (B_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {overflow, carry, result} of the W-bit operation, plain arithmetic
  function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic o);
    logic [W-1:0] be;
    logic [W:0]   s;
    logic         v;
    be = o ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, o};
    v  = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    return {v, s};
  endfunction

  // Timeline model: count edges since an accepted start
  logic         m_phase;
  int           m_cnt;
  logic [W+1:0] m_pend;
  logic [W-1:0] m_res;
  logic         m_co, m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 1'b0;
      m_cnt   <= 0;
      m_pend  <= '0;
      m_res   <= '0;
      m_co    <= 1'b0;
      m_ov    <= 1'b0;
    end else if (!m_phase) begin
      if (start) begin
        m_phase <= 1'b1;
        m_cnt   <= 0;
        m_pend  <= model_op(A_in, B_in, op);
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == K) begin
        m_res <= m_pend[W-1:0];
        m_co  <= m_pend[W];
        m_ov  <= m_pend[W+1];
      end
      if (m_cnt == K + 1) m_phase <= 1'b0;
    end
  end

  logic exp_busy, exp_done;
  assign exp_busy = m_phase && (m_cnt <= K);
  assign exp_done = m_phase && (m_cnt == K + 1);

  always @(negedge clk) begin
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    if (!exp_busy) begin
      chk("result", result, m_res);
      chk("carry_out", carry_out, m_co);
      chk("overflow", overflow, m_ov);
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic o, input logic [W-1:0] er, input logic ec,
                        input logic ev, input bit poke);
    int t;
    t = 0;
    @(negedge clk);
    start = 1'b1; A_in = a; B_in = b; op = o;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; A_in = ~a; B_in = ~b; op = ~o;
      end
      if (poke && i == 3) begin
        start = 1'b1; A_in = 16'h1111;
      end
      if (poke && i == 4) start = 1'b0;
      if (done) begin
        t = i;
        break;
      end
    end
    chk({name, "_latency"}, t, K + 2);
    chk({name, "_result"}, result, er);
    chk({name, "_carry"}, carry_out, ec);
    chk({name, "_ovf"}, overflow, ev);
    @(negedge clk);
    chk({name, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    int t1, t2, n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("pin_sub", model_op(16'h0005, 16'h0007, 1'b1), {2'b00, 16'hFFFE});
    chk("pin_ovf", model_op(16'h7FFF, 16'h0001, 1'b0), {2'b10, 16'h8000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ripple", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    // abort in the second RUN cycle
    @(negedge clk);
    start = 1'b1; A_in = 16'h4321; B_in = 16'h1234; op = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("poke", 16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0, 1'b1);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; A_in = 16'h0003; B_in = 16'h0004; op = 1'b0;
    t1 = 0; t2 = 0; n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) t1 = i;
        else begin
          t2 = i;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_seen", n, 2);
    chk("b2b_gap", t2 - t1, K + 3);
    chk("b2b_result", result, 16'h0007);
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
